// File: rtl/interp_row_sched_if.sv
// Handshake and control bundle between a block requester and the interpolation row scheduler.
interface interp_row_sched_if #(
  parameter int ADDR_W = 8
) ();
  logic              start;
  logic [6:0]        blk_h;
  logic [1:0]        frac_x;
  logic [1:0]        frac_y;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              load;
  logic              adv;
  logic [7:0]        sel;
  logic              out_valid;
  logic [5:0]        out_row;
  logic              out_ready;

  modport master (
    output start, blk_h, frac_x, frac_y, base_addr, out_ready,
    input  busy, done, rd_en, rd_addr, load, adv, sel, out_valid, out_row
  );

  modport slave (
    input  start, blk_h, frac_x, frac_y, base_addr, out_ready,
    output busy, done, rd_en, rd_addr, load, adv, sel, out_valid, out_row
  );
endinterface

// File: rtl/interp_row_sched.sv
// Row sequencer for HEVC sub-pixel interpolation: issues reference-row reads, load strobes,
// filter phase select and tracks pipeline validity so every filtered row carries its index.
module interp_row_sched #(
  parameter int ADDR_W   = 8,
  parameter int PIPE_LAT = 2,
  parameter int MAX_H    = 64
) (
  input  logic              clk,
  input  logic              reset,
  interp_row_sched_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [6:0]          h_q, h_d;
  logic                vbyp_q, vbyp_d;
  logic [6:0]          rem_q, rem_d;
  logic [6:0]          lcnt_q, lcnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          sel_q, sel_d;
  logic                vload_q, vload_d;
  logic [PIPE_LAT-1:0] vstg_q, vstg_d;
  logic [5:0]          row_q, row_d;

  logic       out_valid, active, adv, rd_en, load, hs;
  logic [6:0] h_clamp;

  assign out_valid = vstg_q[PIPE_LAT-1];
  assign active    = (state_q != S_IDLE);
  assign adv       = active & ~(out_valid & ~bus.out_ready);
  assign rd_en     = (state_q == S_RUN) & (rem_q != 7'd0) & adv;
  assign load      = vload_q & adv;
  assign hs        = out_valid & bus.out_ready;
  assign h_clamp   = (bus.blk_h > 7'(MAX_H)) ? 7'(MAX_H) : bus.blk_h;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    vbyp_d  = vbyp_q;
    rem_d   = rem_q;
    lcnt_d  = lcnt_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    vload_d = vload_q;
    vstg_d  = vstg_q;
    row_d   = row_q;

    // Validity chain: issue -> load stage -> PIPE_LAT filter stages, all frozen when adv=0.
    // With vertical filtering the first 7 loads only prime the tap window.
    if (adv) begin
      vload_d   = rd_en;
      vstg_d[0] = load & (vbyp_q | (lcnt_q >= 7'd7));
      for (int i = 1; i < PIPE_LAT; i++) begin
        vstg_d[i] = vstg_q[i-1];
      end
    end
    if (rd_en) begin
      rem_d  = rem_q - 7'd1;
      addr_d = addr_q + ADDR_W'(1);
    end
    if (load) lcnt_d = lcnt_q + 7'd1;
    if (hs)   row_d  = row_q + 6'd1;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          h_d     = h_clamp;
          vbyp_d  = (bus.frac_y == 2'd0);
          sel_d   = {2'b00, bus.frac_y == 2'd0, bus.frac_x == 2'd0, bus.frac_y, bus.frac_x};
          lcnt_d  = 7'd0;
          row_d   = 6'd0;
          if (h_clamp == 7'd0) rem_d = 7'd0;
          else if (bus.frac_y == 2'd0) rem_d = h_clamp;
          else rem_d = h_clamp + 7'd7;
          addr_d  = (bus.frac_y == 2'd0) ? bus.base_addr : bus.base_addr - ADDR_W'(3);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (h_q == 7'd0) state_d = S_DONE;
        else if (rd_en && rem_q == 7'd1) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (hs && ({1'b0, row_q} == h_q - 7'd1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      vbyp_q  <= 1'b0;
      rem_q   <= '0;
      lcnt_q  <= '0;
      addr_q  <= '0;
      sel_q   <= '0;
      vload_q <= 1'b0;
      vstg_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      vbyp_q  <= vbyp_d;
      rem_q   <= rem_d;
      lcnt_q  <= lcnt_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      vload_q <= vload_d;
      vstg_q  <= vstg_d;
      row_q   <= row_d;
    end
  end

  assign bus.busy      = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = addr_q;
  assign bus.load      = load;
  assign bus.adv       = adv;
  assign bus.sel       = sel_q;
  assign bus.out_valid = out_valid;
  assign bus.out_row   = row_q;

endmodule

// File: tb/tb_interp_row_sched.sv
// Self-checking bench for interp_row_sched against a cycle-level reference of the block schedule.
module tb_interp_row_sched;
  localparam int ADDR_W   = 8;
  localparam int PIPE_LAT = 2;
  localparam int MAX_H    = 64;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   done_cyc;

  always #5 clk = ~clk;

  interp_row_sched_if #(.ADDR_W(ADDR_W)) ifc ();

  interp_row_sched #(.ADDR_W(ADDR_W), .PIPE_LAT(PIPE_LAT), .MAX_H(MAX_H)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  // Reference: an unstalled schedule indexed by effective cycle e; stall cycles do not advance e.
  // mode 0: out_ready always 1; mode 1: out_ready low on cycles 5-6; mode 2: random out_ready.
  task automatic run_block(input int blk_h, input int fx, input int fy, input int base,
                           input int mode, input bit poke_start);
    int h, n, off, first, e, end_e, cyc, reads_seen, rows_seen, exp_row, exp_addr, k;
    bit exp_busy, exp_done, exp_rd, exp_load, exp_ov, exp_adv, act, rdy, stall;
    logic [7:0] exp_sel;
    h     = (blk_h > MAX_H) ? MAX_H : blk_h;
    off   = (fy != 0) ? 7 : 0;
    n     = (h == 0) ? 0 : h + off;
    first = ((fy != 0) ? base - 3 : base) & ((1 << ADDR_W) - 1);
    exp_sel = 8'(((fy == 0) ? 32 : 0) + ((fx == 0) ? 16 : 0) + fy * 4 + fx);
    end_e = (h == 0) ? 3 : n + 3 + PIPE_LAT;

    @(negedge clk);
    ifc.start     = 1'b1;
    ifc.blk_h     = 7'(blk_h);
    ifc.frac_x    = 2'(fx);
    ifc.frac_y    = 2'(fy);
    ifc.base_addr = ADDR_W'(base);
    ifc.out_ready = 1'b1;
    e = 1; done_cyc = -1; reads_seen = 0; rows_seen = 0;

    for (cyc = 1; cyc <= 3000 && e <= end_e; cyc++) begin
      @(negedge clk);
      ifc.start = poke_start && (cyc == 3);
      if (poke_start && cyc == 3) ifc.blk_h = 7'd9;
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = !(cyc == 5 || cyc == 6);
      else rdy = ($urandom_range(0, 3) != 0);
      ifc.out_ready = rdy;
      #1;
      k        = e - 2 - PIPE_LAT - off;
      exp_ov   = (h > 0) && (k >= 0) && (k < h);
      exp_row  = k;
      stall    = exp_ov && !rdy;
      act      = (h == 0) ? (e <= 2) : (e <= n + 2 + PIPE_LAT);
      exp_busy = (h == 0) ? (e == 1) : (e <= n + 1 + PIPE_LAT);
      exp_done = (h == 0) ? (e == 2) : (e == n + 2 + PIPE_LAT);
      exp_rd   = !stall && (e <= n);
      exp_load = !stall && (e >= 2) && (e <= n + 1);
      exp_adv  = act && !stall;
      exp_addr = (first + e - 1) & ((1 << ADDR_W) - 1);

      total++; if (ifc.busy !== exp_busy) begin bad++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, ifc.busy, exp_busy); end
      total++; if (ifc.done !== exp_done) begin bad++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, ifc.done, exp_done); end
      total++; if (ifc.rd_en !== exp_rd) begin bad++; $display("FAIL rd_en cyc=%0d got=%b exp=%b", cyc, ifc.rd_en, exp_rd); end
      total++; if (ifc.load !== exp_load) begin bad++; $display("FAIL load cyc=%0d got=%b exp=%b", cyc, ifc.load, exp_load); end
      total++; if (ifc.adv !== exp_adv) begin bad++; $display("FAIL adv cyc=%0d got=%b exp=%b", cyc, ifc.adv, exp_adv); end
      total++; if (ifc.out_valid !== exp_ov) begin bad++; $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, ifc.out_valid, exp_ov); end
      total++; if (ifc.sel !== exp_sel) begin bad++; $display("FAIL sel cyc=%0d got=%h exp=%h", cyc, ifc.sel, exp_sel); end
      if (exp_rd) begin
        total++; if (ifc.rd_addr !== ADDR_W'(exp_addr)) begin bad++; $display("FAIL rd_addr cyc=%0d got=%h exp=%h", cyc, ifc.rd_addr, ADDR_W'(exp_addr)); end
      end
      if (exp_ov) begin
        total++; if (ifc.out_row !== 6'(exp_row)) begin bad++; $display("FAIL out_row cyc=%0d got=%0d exp=%0d", cyc, ifc.out_row, exp_row); end
      end
      if (ifc.rd_en === 1'b1) reads_seen++;
      if (ifc.done === 1'b1) done_cyc = cyc;
      if (ifc.out_valid === 1'b1 && rdy) rows_seen++;
      if (!stall) e++;
    end
    ifc.start = 1'b0;
    total++; if (e <= end_e) begin bad++; $display("FAIL timeout got_e=%0d exp_e=%0d", e, end_e + 1); end
    total++; if (reads_seen != n) begin bad++; $display("FAIL read_count got=%0d exp=%0d", reads_seen, n); end
    total++; if (rows_seen != h) begin bad++; $display("FAIL row_count got=%0d exp=%0d", rows_seen, h); end
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if ({ifc.busy, ifc.done, ifc.rd_en, ifc.load, ifc.adv, ifc.out_valid} !== 6'b0 ||
        ifc.rd_addr !== '0 || ifc.sel !== 8'h00 || ifc.out_row !== 6'd0) begin
      bad++;
      $display("FAIL %s outputs busy=%b done=%b rd_en=%b load=%b adv=%b ov=%b addr=%h sel=%h row=%0d exp all 0",
               tag, ifc.busy, ifc.done, ifc.rd_en, ifc.load, ifc.adv, ifc.out_valid,
               ifc.rd_addr, ifc.sel, ifc.out_row);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifc.start = 1'b0; ifc.blk_h = '0; ifc.frac_x = '0; ifc.frac_y = '0;
    ifc.base_addr = '0; ifc.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
  endtask

  task automatic test_full_pel();
    run_block(4, 0, 0, 'h10, 0, 1'b0);
    total++; if (done_cyc != 8) begin bad++; $display("FAIL full_pel_done got=%0d exp=8", done_cyc); end
  endtask

  task automatic test_vertical();
    run_block(4, 1, 2, 'h20, 0, 1'b0);
    total++; if (done_cyc != 15) begin bad++; $display("FAIL vertical_done got=%0d exp=15", done_cyc); end
  endtask

  task automatic test_wrap();
    run_block(2, 0, 1, 'h01, 0, 1'b0);
  endtask

  task automatic test_stall();
    run_block(4, 0, 0, 'h10, 1, 1'b0);
    total++; if (done_cyc != 10) begin bad++; $display("FAIL stall_done got=%0d exp=10", done_cyc); end
  endtask

  task automatic test_control_corners();
    run_block(4, 0, 0, 'h40, 0, 1'b1);
    run_block(0, 2, 3, 'h80, 0, 1'b0);
    total++; if (done_cyc != 2) begin bad++; $display("FAIL empty_done got=%0d exp=2", done_cyc); end
    run_block(100, 0, 0, 'h00, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ifc.start = 1'b1; ifc.blk_h = 7'd4; ifc.frac_x = 2'd1; ifc.frac_y = 2'd2;
    ifc.base_addr = ADDR_W'('h20); ifc.out_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      ifc.start = 1'b0;
      if (c == 3) begin
        #1;
        total++; if (ifc.rd_en !== 1'b1) begin bad++; $display("FAIL mid_rd_en got=%b exp=1", ifc.rd_en); end
        reset = 1'b1;
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid");
    run_block(4, 0, 0, 'h10, 0, 1'b0);
    total++; if (done_cyc != 8) begin bad++; $display("FAIL after_reset_done got=%0d exp=8", done_cyc); end
  endtask

  task automatic test_back_to_back();
    run_block(3, 3, 0, 'hF0, 0, 1'b0);
    run_block(5, 0, 3, 'h02, 2, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_block($urandom_range(0, 80), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 255), 2, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_full_pel();
    test_vertical();
    test_wrap();
    test_stall();
    test_control_corners();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
